exec_operand_stage: RTL and testbench
=====================================

# exec_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It registers the decoded operands, immediate, destination, and 14-bit ALU control word. In EX it resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages and drives the ALU's A, B and AluControl inputs. It also raises a load-use stall request to the hazard unit and inserts bubbles on stall, flush, or load-use.

## Interface
Parameters:
- WORD_W, 16, datapath width
- REG_W, 3, register-index width (8 GPRs)
- CTL_W, 14, ALU control width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- Stall  in  1  external hold of ID/EX contents
- Flush  in  1  squash: load bubble next edge
- IdValid  in  1  ID holds a real instruction
- IdRegA, IdRegB  in  WORD_W  register-file read data
- IdRsA, IdRsB  in  REG_W  source indices
- IdUsesA, IdUsesB  in  1  operand is architecturally read
- IdImm  in  WORD_W  extended immediate
- IdUseImm  in  1  B takes immediate instead of IdRegB
- IdAluControl  in  CTL_W  decoded ALU control
- IdWrEn, IdMemRead  in  1  writes GPR / is load
- IdWrReg  in  REG_W  destination
- ExMemWrEn, MemWbWrEn  in  1  downstream writers valid
- ExMemWrReg, MemWbWrReg  in  REG_W
- ExMemResult, MemWbResult  in  WORD_W
- A, B  out  WORD_W  ALU operands (forwarded)
- AluControl  out  CTL_W
- ExValid, ExWrEn, ExMemRead  out  1
- ExWrReg  out  REG_W
- LoadUseStall  out  1  request hazard unit to freeze PC/IF/ID

## Operation
- Stage register holds: Valid, RegA, RegB, RsA, RsB, UsesA, UsesB, Imm, UseImm, AluControl, WrEn, WrReg, MemRead.
- Bubble: Valid=0, WrEn=0, MemRead=0, UsesA=UsesB=0, AluControl=14'h0000 (ALU output select 00 → Out=0). Other fields are don't-care, driven 0.
- Edge update priority: rst → bubble; else Flush → bubble; else Stall → hold all; else LoadUseStall → bubble; else load ID fields (Valid=IdValid; WrEn/MemRead gated by IdValid).
- LoadUseStall = ExValid & ExMemRead & IdValid & ((IdUsesA & IdRsA==ExWrReg) | (IdUsesB & ~IdUseImm & IdRsB==ExWrReg)).
- Forwarding for operand A (combinational, EX): if UsesA & ExMemWrEn & ExMemWrReg==RsA → ExMemResult. Else if UsesA & MemWbWrEn & MemWbWrReg==RsA → MemWbResult. Else RegA. The nearer stage (EX/MEM) wins when both match.
- Operand B: if UseImm → Imm (never forwarded); else the same rule on RsB/UsesB/RegB.
- Register-file write-through in the same cycle as MEM/WB is the register file's job; this block only covers it via the MEM/WB forward.
- ExWrEn, ExWrReg, ExMemRead, ExValid, AluControl are straight register outputs.

## Timing
- Latency: ID fields visible on AluControl/ExWrReg one cycle after capture edge.
- A/B: combinational from stage register plus same-cycle ExMem/MemWb inputs; no extra cycle.
- LoadUseStall: combinational, same cycle as the dependent instruction sits in ID. On the following edge a bubble enters EX and the load moves to MEM. LoadUseStall deasserts and the MEM/WB forward supplies the data one cycle later.
- Stall with LoadUseStall both high: hold (Stall wins); the request persists.
- Flush with Stall: bubble (Flush wins).
- Reset mid-operation: bubble on next edge regardless of Stall/Flush. All outputs are 0 after reset, except A/B, which reflect forwarding of the zero state (0 with no matches).

## Configuration
- EXEC_FWD_EN defined: forwarding as above; LoadUseStall only for load-use.
- Undefined: A=RegA, B=UseImm?Imm:RegB, no forwarding. LoadUseStall becomes a general RAW stall, asserted when an ID source (used, non-immediate) matches ExWrReg with ExValid&ExWrEn, or ExMemWrReg with ExMemWrEn. The MEM/WB case relies on register-file write-through.

## Structure
- Shared package/include holds WORD_W, REG_W, CTL_W, BUBBLE_ALUCTL (14'h0000), and the stage-register field bundle definition.
- One sub-module: operand_fwd_mux (inputs: Uses, Rs, RegVal, ExMem/MemWb wr-en/reg/result; output: operand), instantiated for A and for B. B's immediate select sits outside it.

## Test plan
- Reset: rst=1 two cycles with IdValid=1 → ExValid=0, ExWrEn=0, AluControl=0, A=B=0.
- EX/MEM forward: EX has RsA=3, RegA=16'h0005; ExMemWrEn=1, ExMemWrReg=3, ExMemResult=16'h1234 → A=16'h1234.
- Priority: both stages write r3 (ExMem=16'hAAAA, MemWb=16'hBBBB) with RsB=3, UseImm=0 → B=16'hAAAA. With UseImm=1, Imm=16'h0007 → B=16'h0007.
- Load-use: EX holds load to r2 (ExMemRead=1); ID reads r2 on A → LoadUseStall=1. Next edge ExValid=0, AluControl=0. A cycle later, with MemWbResult=16'h00FF for r2 → A=16'h00FF.
- Stall/Flush: capture instruction, then Stall=1 for 3 cycles with changing ID inputs → stage contents unchanged. Then Stall=1, Flush=1 together → bubble.
- Build without EXEC_FWD_EN: ID reads r4 while ExMemWrReg=4, ExMemWrEn=1 → LoadUseStall=1, and A equals raw RegA.

Source files
------------

// File: rtl/exec_operand_stage_pkg.sv
// Shared widths, bubble control word and the ID/EX stage-register bundle
// for exec_operand_stage and its forwarding mux.
package exec_operand_stage_pkg;

   localparam int WORD_W = 16;
   localparam int REG_W  = 3;
   localparam int CTL_W  = 14;

   // ALU output select 00 -> Out=0, so a bubble produces no result.
   localparam logic [CTL_W-1:0] BUBBLE_ALUCTL = 14'h0000;

   typedef struct packed {
      logic              valid;
      logic [WORD_W-1:0] rega;
      logic [WORD_W-1:0] regb;
      logic [REG_W-1:0]  rsa;
      logic [REG_W-1:0]  rsb;
      logic              usesa;
      logic              usesb;
      logic [WORD_W-1:0] imm;
      logic              useimm;
      logic [CTL_W-1:0]  aluctl;
      logic              wren;
      logic [REG_W-1:0]  wrreg;
      logic              mread;
   } stage_t;

   // Bubble: nothing valid, nothing written, nothing read; don't-cares at 0.
   function automatic stage_t stage_bubble();
      stage_t s;
      s        = '0;
      s.aluctl = BUBBLE_ALUCTL;
      return s;
   endfunction

endpackage

// File: rtl/exec_operand_stage_fwd_mux.sv
// Single-operand RAW forwarding mux (EX/MEM beats MEM/WB).
// Forwarding only exists when EXEC_FWD_EN is defined; otherwise the
// operand is the raw register-file value.
module operand_fwd_mux #(
   parameter int WORD_W = exec_operand_stage_pkg::WORD_W,
   parameter int REG_W  = exec_operand_stage_pkg::REG_W
) (
   input  logic              Uses_i,
   input  logic [REG_W-1:0]  Rs_i,
   input  logic [WORD_W-1:0] RegVal_i,
   input  logic              ExMemWrEn_i,
   input  logic [REG_W-1:0]  ExMemWrReg_i,
   input  logic [WORD_W-1:0] ExMemResult_i,
   input  logic              MemWbWrEn_i,
   input  logic [REG_W-1:0]  MemWbWrReg_i,
   input  logic [WORD_W-1:0] MemWbResult_i,
   output logic [WORD_W-1:0] Operand_o
);

`ifdef EXEC_FWD_EN
   // Pick the youngest in-flight writer of Rs; EX/MEM is assigned last so it wins.
   always_comb begin
      Operand_o = RegVal_i;
      if (Uses_i && MemWbWrEn_i && (MemWbWrReg_i == Rs_i)) Operand_o = MemWbResult_i;
      if (Uses_i && ExMemWrEn_i && (ExMemWrReg_i == Rs_i)) Operand_o = ExMemResult_i;
   end
`else
   assign Operand_o = RegVal_i;

   // Hazards are stalled instead of forwarded, so the bypass inputs are idle.
   logic unused_fwd;
   assign unused_fwd = ^{Uses_i, Rs_i, ExMemWrEn_i, ExMemWrReg_i, ExMemResult_i,
                         MemWbWrEn_i, MemWbWrReg_i, MemWbResult_i};
`endif

endmodule

// File: rtl/exec_operand_stage.sv
// ID/EX stage register feeding the ALU: captures decoded operands, resolves
// RAW hazards and requests load-use (or, without forwarding, RAW) stalls.
// Build option: define EXEC_FWD_EN to enable EX/MEM and MEM/WB forwarding.
// Widths must match the stage_t bundle in exec_operand_stage_pkg.
module exec_operand_stage #(
   parameter int WORD_W = exec_operand_stage_pkg::WORD_W,
   parameter int REG_W  = exec_operand_stage_pkg::REG_W,
   parameter int CTL_W  = exec_operand_stage_pkg::CTL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              IdValid,
   input  logic [WORD_W-1:0] IdRegA,
   input  logic [WORD_W-1:0] IdRegB,
   input  logic [REG_W-1:0]  IdRsA,
   input  logic [REG_W-1:0]  IdRsB,
   input  logic              IdUsesA,
   input  logic              IdUsesB,
   input  logic [WORD_W-1:0] IdImm,
   input  logic              IdUseImm,
   input  logic [CTL_W-1:0]  IdAluControl,
   input  logic              IdWrEn,
   input  logic              IdMemRead,
   input  logic [REG_W-1:0]  IdWrReg,
   input  logic              ExMemWrEn,
   input  logic              MemWbWrEn,
   input  logic [REG_W-1:0]  ExMemWrReg,
   input  logic [REG_W-1:0]  MemWbWrReg,
   input  logic [WORD_W-1:0] ExMemResult,
   input  logic [WORD_W-1:0] MemWbResult,
   output logic [WORD_W-1:0] A,
   output logic [WORD_W-1:0] B,
   output logic [CTL_W-1:0]  AluControl,
   output logic              ExValid,
   output logic              ExWrEn,
   output logic              ExMemRead,
   output logic [REG_W-1:0]  ExWrReg,
   output logic              LoadUseStall
);
   import exec_operand_stage_pkg::*;

   stage_t st_q, st_d;
   logic [WORD_W-1:0] fwd_b;
   logic haz_a, haz_b;

`ifdef EXEC_FWD_EN
   // Only a load in EX cannot be bypassed: its data appears one stage too late.
   assign haz_a = IdUsesA && (IdRsA == st_q.wrreg);
   assign haz_b = IdUsesB && !IdUseImm && (IdRsB == st_q.wrreg);
   assign LoadUseStall = st_q.valid && st_q.mread && IdValid && (haz_a || haz_b);
`else
   // No bypass: any pending writer in EX or EX/MEM blocks the reader in ID.
   // MEM/WB is covered by register-file write-through.
   assign haz_a = IdUsesA &&
                  ((st_q.valid && st_q.wren && (IdRsA == st_q.wrreg)) ||
                   (ExMemWrEn && (IdRsA == ExMemWrReg)));
   assign haz_b = IdUsesB && !IdUseImm &&
                  ((st_q.valid && st_q.wren && (IdRsB == st_q.wrreg)) ||
                   (ExMemWrEn && (IdRsB == ExMemWrReg)));
   assign LoadUseStall = IdValid && (haz_a || haz_b);
`endif

   // Next stage contents: Flush > Stall(hold) > hazard bubble > capture ID.
   always_comb begin
      st_d = st_q;
      if (Flush) begin
         st_d = stage_bubble();
      end else if (Stall) begin
         st_d = st_q;
      end else if (LoadUseStall) begin
         st_d = stage_bubble();
      end else begin
         st_d.valid  = IdValid;
         st_d.rega   = IdRegA;
         st_d.regb   = IdRegB;
         st_d.rsa    = IdRsA;
         st_d.rsb    = IdRsB;
         st_d.usesa  = IdUsesA;
         st_d.usesb  = IdUsesB;
         st_d.imm    = IdImm;
         st_d.useimm = IdUseImm;
         st_d.aluctl = IdAluControl;
         st_d.wren   = IdWrEn && IdValid;
         st_d.wrreg  = IdWrReg;
         st_d.mread  = IdMemRead && IdValid;
      end
   end

   // Stage register; reset overrides everything with a bubble.
   always_ff @(posedge clk) begin
      if (rst) st_q <= stage_bubble();
      else     st_q <= st_d;
   end

   operand_fwd_mux #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_a (
      .Uses_i(st_q.usesa), .Rs_i(st_q.rsa), .RegVal_i(st_q.rega),
      .ExMemWrEn_i(ExMemWrEn), .ExMemWrReg_i(ExMemWrReg), .ExMemResult_i(ExMemResult),
      .MemWbWrEn_i(MemWbWrEn), .MemWbWrReg_i(MemWbWrReg), .MemWbResult_i(MemWbResult),
      .Operand_o(A)
   );

   operand_fwd_mux #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_b (
      .Uses_i(st_q.usesb), .Rs_i(st_q.rsb), .RegVal_i(st_q.regb),
      .ExMemWrEn_i(ExMemWrEn), .ExMemWrReg_i(ExMemWrReg), .ExMemResult_i(ExMemResult),
      .MemWbWrEn_i(MemWbWrEn), .MemWbWrReg_i(MemWbWrReg), .MemWbResult_i(MemWbResult),
      .Operand_o(fwd_b)
   );

   // Immediates are never forwarded.
   assign B          = st_q.useimm ? st_q.imm : fwd_b;
   assign AluControl = st_q.aluctl;
   assign ExValid    = st_q.valid;
   assign ExWrEn     = st_q.wren;
   assign ExMemRead  = st_q.mread;
   assign ExWrReg    = st_q.wrreg;

endmodule

// File: tb/tb_exec_operand_stage.sv
// Randomized + directed bench for exec_operand_stage with an in-bench
// behavioural model of the ID/EX stage (follows EXEC_FWD_EN like the DUT).
module tb_exec_operand_stage;

   logic clk, rst, Stall, Flush, IdValid;
   logic [15:0] IdRegA, IdRegB, IdImm, ExMemResult, MemWbResult;
   logic [2:0]  IdRsA, IdRsB, IdWrReg, ExMemWrReg, MemWbWrReg;
   logic        IdUsesA, IdUsesB, IdUseImm, IdWrEn, IdMemRead, ExMemWrEn, MemWbWrEn;
   logic [13:0] IdAluControl;
   logic [15:0] A, B;
   logic [13:0] AluControl;
   logic        ExValid, ExWrEn, ExMemRead, LoadUseStall;
   logic [2:0]  ExWrReg;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   exec_operand_stage dut (
      .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .IdValid(IdValid),
      .IdRegA(IdRegA), .IdRegB(IdRegB), .IdRsA(IdRsA), .IdRsB(IdRsB),
      .IdUsesA(IdUsesA), .IdUsesB(IdUsesB), .IdImm(IdImm), .IdUseImm(IdUseImm),
      .IdAluControl(IdAluControl), .IdWrEn(IdWrEn), .IdMemRead(IdMemRead),
      .IdWrReg(IdWrReg), .ExMemWrEn(ExMemWrEn), .MemWbWrEn(MemWbWrEn),
      .ExMemWrReg(ExMemWrReg), .MemWbWrReg(MemWbWrReg),
      .ExMemResult(ExMemResult), .MemWbResult(MemWbResult),
      .A(A), .B(B), .AluControl(AluControl), .ExValid(ExValid), .ExWrEn(ExWrEn),
      .ExMemRead(ExMemRead), .ExWrReg(ExWrReg), .LoadUseStall(LoadUseStall)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Model of the instruction currently sitting in EX.
   typedef struct packed {
      logic v; logic [15:0] ra, rb; logic [2:0] sa, sb; logic ua, ub;
      logic [15:0] im; logic ui; logic [13:0] ctl; logic we; logic [2:0] wr; logic mr;
   } mst_t;
   mst_t m;

   // Value an EX source must see: youngest in-flight writer, else register file.
   function automatic logic [15:0] m_operand(logic uses, logic [2:0] rs, logic [15:0] rv);
`ifdef EXEC_FWD_EN
      if (uses && ExMemWrEn && ExMemWrReg == rs) return ExMemResult;
      if (uses && MemWbWrEn && MemWbWrReg == rs) return MemWbResult;
`endif
      return rv;
   endfunction

   // Does the instruction in ID have to wait?
   function automatic logic exp_lus();
      logic ra, rb;
`ifdef EXEC_FWD_EN
      ra = IdUsesA && m.v && m.mr && IdRsA == m.wr;
      rb = IdUsesB && !IdUseImm && m.v && m.mr && IdRsB == m.wr;
`else
      ra = IdUsesA && ((m.v && m.we && IdRsA == m.wr) || (ExMemWrEn && IdRsA == ExMemWrReg));
      rb = IdUsesB && !IdUseImm &&
           ((m.v && m.we && IdRsB == m.wr) || (ExMemWrEn && IdRsB == ExMemWrReg));
`endif
      return IdValid && (ra || rb);
   endfunction

   function automatic mst_t next_m();
      mst_t n;
      n = m;
      if (rst || Flush) n = '0;
      else if (Stall) n = m;
      else if (exp_lus()) n = '0;
      else begin
         n.v = IdValid; n.ra = IdRegA; n.rb = IdRegB; n.sa = IdRsA; n.sb = IdRsB;
         n.ua = IdUsesA; n.ub = IdUsesB; n.im = IdImm; n.ui = IdUseImm;
         n.ctl = IdAluControl; n.we = IdWrEn && IdValid; n.wr = IdWrReg;
         n.mr = IdMemRead && IdValid;
      end
      return n;
   endfunction

   always @(posedge clk) m <= next_m();

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h @%0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m.A", A, m_operand(m.ua, m.sa, m.ra));
         check("m.B", B, m.ui ? m.im : m_operand(m.ub, m.sb, m.rb));
         check("m.AluControl", AluControl, m.ctl);
         check("m.ExValid", ExValid, m.v);
         check("m.ExWrEn", ExWrEn, m.we);
         check("m.ExMemRead", ExMemRead, m.mr);
         check("m.ExWrReg", ExWrReg, m.wr);
         check("m.LoadUseStall", LoadUseStall, exp_lus());
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_id(input logic v, input logic [15:0] ra, input logic [15:0] rb,
                           input logic [2:0] sa, input logic [2:0] sb, input logic ua,
                           input logic ub, input logic [15:0] im, input logic ui,
                           input logic [13:0] ctl, input logic we, input logic [2:0] wr,
                           input logic mr);
      IdValid = v; IdRegA = ra; IdRegB = rb; IdRsA = sa; IdRsB = sb; IdUsesA = ua;
      IdUsesB = ub; IdImm = im; IdUseImm = ui; IdAluControl = ctl; IdWrEn = we;
      IdWrReg = wr; IdMemRead = mr;
   endtask

   task automatic wb_idle();
      ExMemWrEn = 0; ExMemWrReg = 0; ExMemResult = 0;
      MemWbWrEn = 0; MemWbWrReg = 0; MemWbResult = 0;
   endtask

   initial begin
      rst = 1; Stall = 0; Flush = 0;
      wb_idle();
      drive_id(1, 16'h0001, 16'h0002, 3'd1, 3'd2, 1, 1, 16'h0003, 0, 14'h3FFF, 1, 3'd7, 1);

      // Reset held two cycles with a valid instruction in ID.
      cyc(); chk_en = 1; cyc();
      check("rst.ExValid", ExValid, 0);
      check("rst.ExWrEn", ExWrEn, 0);
      check("rst.AluControl", AluControl, 0);
      check("rst.A", A, 0);
      check("rst.B", B, 0);

      // Capture, then hold for 3 cycles of Stall while ID changes.
      #1 rst = 0;
      drive_id(1, 16'h1111, 16'h2222, 3'd1, 3'd2, 1, 1, 16'h3333, 0, 14'h1ABC, 1, 3'd5, 0);
      cyc();
      check("cap.AluControl", AluControl, 14'h1ABC);
      check("cap.ExWrReg", ExWrReg, 3'd5);
      check("cap.A", A, 16'h1111);
      check("cap.B", B, 16'h2222);
      check("cap.ExValid", ExValid, 1);
      #1 Stall = 1;
      for (int i = 0; i < 3; i++) begin
         drive_id(1, 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom), 1, 1,
                  16'($urandom), 0, 14'($urandom), 1, 3'($urandom), 0);
         cyc();
         check("hold.AluControl", AluControl, 14'h1ABC);
         check("hold.A", A, 16'h1111);
         check("hold.ExWrReg", ExWrReg, 3'd5);
         #1;
      end
      Flush = 1;
      cyc();
      check("flush.ExValid", ExValid, 0);
      check("flush.AluControl", AluControl, 0);
      check("flush.ExWrEn", ExWrEn, 0);
      #1 Stall = 0; Flush = 0;

      // EX reads r4 while EX/MEM is writing r4; ID also reads r4.
      drive_id(1, 16'h4444, 16'h0000, 3'd4, 3'd0, 1, 0, 16'h0000, 0, 14'h0011, 1, 3'd6, 0);
      cyc();
      #1 ExMemWrEn = 1; ExMemWrReg = 3'd4; ExMemResult = 16'hDEAD;
      #1;
`ifdef EXEC_FWD_EN
      check("raw.A", A, 16'hDEAD);
      check("raw.LoadUseStall", LoadUseStall, 0);
`else
      check("raw.A", A, 16'h4444);
      check("raw.LoadUseStall", LoadUseStall, 1);
`endif
      wb_idle();

`ifdef EXEC_FWD_EN
      // EX/MEM forward on A.
      drive_id(1, 16'h0005, 16'h0000, 3'd3, 3'd0, 1, 0, 16'h0000, 0, 14'h0001, 1, 3'd1, 0);
      cyc();
      #1 ExMemWrEn = 1; ExMemWrReg = 3'd3; ExMemResult = 16'h1234;
      #1 check("fwd.A", A, 16'h1234);
      // Nearer stage wins on B; immediate is never forwarded.
      drive_id(1, 16'h0000, 16'h0009, 3'd0, 3'd3, 0, 1, 16'h0000, 0, 14'h0002, 1, 3'd1, 0);
      cyc();
      #1 ExMemResult = 16'hAAAA; MemWbWrEn = 1; MemWbWrReg = 3'd3; MemWbResult = 16'hBBBB;
      #1 check("prio.B", B, 16'hAAAA);
      drive_id(1, 16'h0000, 16'h0009, 3'd0, 3'd3, 0, 1, 16'h0007, 1, 14'h0003, 1, 3'd1, 0);
      cyc();
      #1 check("imm.B", B, 16'h0007);
      wb_idle();
      // Load to r2, dependent reader of r2 behind it.
      drive_id(1, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 16'h0000, 0, 14'h0100, 1, 3'd2, 1);
      cyc();
      #1 drive_id(1, 16'h0000, 16'h0000, 3'd2, 3'd0, 1, 0, 16'h0000, 0, 14'h0022, 1, 3'd3, 0);
      #1 check("lu.LoadUseStall", LoadUseStall, 1);
      cyc();
      check("lu.ExValid", ExValid, 0);
      check("lu.AluControl", AluControl, 0);
      cyc();
      #1 MemWbWrEn = 1; MemWbWrReg = 3'd2; MemWbResult = 16'h00FF;
      #1 check("lu.A", A, 16'h00FF);
      check("lu.ctl", AluControl, 14'h0022);
      wb_idle();
`endif

      // Randomized traffic; small register range to provoke hazards often.
      for (int i = 0; i < 3000; i++) begin
         #1;
         rst   = ($urandom_range(0, 63) == 0);
         Flush = ($urandom_range(0, 15) == 0);
         Stall = ($urandom_range(0, 7) == 0);
         drive_id($urandom_range(0, 7) != 0, 16'($urandom), 16'($urandom),
                  3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                  14'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0));
         ExMemWrEn = 1'($urandom); ExMemWrReg = 3'($urandom_range(0, 3));
         ExMemResult = 16'($urandom);
         MemWbWrEn = 1'($urandom); MemWbWrReg = 3'($urandom_range(0, 3));
         MemWbResult = 16'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
